load_bram_burst: RTL and testbench
==================================

# load_bram_burst

Parametrised successor to the pixel FIFO-to-BRAM loader: drains a standard (non-FWFT) pixel FIFO in fixed-length bursts and writes each word to consecutive BRAM locations from a programmable base address. It adds run-time base/length programming, burst-gated reads keyed on the FIFO read count, a continuous frame-loop mode, abort, and a done pulse. It sits between `px_in_fifo` and port A of the display-map BRAM, in the same clock domain.

## Interface
- `DATA_W`, 32: FIFO/BRAM word width; multiple of 8.
- `ADDR_W`, 32: BRAM byte-address width.
- `COUNT_W`, 11: width of the FIFO `rd_data_count`.
- `LEN_W`, 20: width of the word-count register.
- `BURST_LEN`, 16: words per burst; 1 ≤ `BURST_LEN` < 2^`COUNT_W`.
- `clk` in 1: the only clock. Reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; latches `base_addr`, `num_words` and `loop_mode`.
- `base_addr` in `ADDR_W`: first byte address; must be aligned to `DATA_W/8`.
- `num_words` in `LEN_W`: words per frame.
- `loop_mode` in 1: 1 = restart at `base_addr` after each frame until abort.
- `abort` in 1: stop after any in-flight word.
- `ren_fifo` out 1: FIFO read enable.
- `din_fifo` in `DATA_W`: FIFO dout, valid the cycle after `ren_fifo`.
- `empty_fifo` in 1: FIFO empty.
- `rd_data_count_fifo` in `COUNT_W`: FIFO occupancy.
- `en_bram` out 1: BRAM port enable.
- `we_bram` out `DATA_W/8`: byte write enables; all ones on a write, else 0.
- `addr_bram` out `ADDR_W`: byte address.
- `din_bram` out `DATA_W`: write data.
- `busy` out 1: high from the cycle after an accepted `start` until the return to IDLE.
- `done` out 1: one-cycle pulse per completed frame.

## Operation
- Every output resets to 0. The FSM resets to IDLE.
- States:
  - IDLE: a `start` moves to WAIT (or to DONE if `num_words` = 0). `start` is ignored in every other state.
  - WAIT: compute `b` = min(`BURST_LEN`, remaining). When `rd_data_count_fifo` ≥ `b`, load the burst counter with `b` and move to READ.
  - READ: `ren_fifo` = 1 while the burst counter > 0 and `empty_fifo` = 0. Each read decrements the burst counter and remaining. When the burst counter reaches 0, go to WAIT if remaining > 0, else to DRAIN.
  - DRAIN: one cycle for the final write, then DONE.
  - DONE: pulse `done`. If `loop_mode` = 1, reload the address and remaining from the latched values and go to WAIT. Otherwise go to IDLE.
- Write pipeline: a registered `rd_valid` is `ren_fifo` delayed one cycle. When `rd_valid` = 1, drive `en_bram` = 1, `we_bram` = all ones, `din_bram` = `din_fifo`, and `addr_bram` = the current address. The address then advances by `DATA_W/8`.
- Address arithmetic is modulo 2^`ADDR_W` and wraps silently.
- `ren_fifo` is never asserted while `empty_fifo` = 1. It never exceeds the remaining count for the frame.
- abort: any state other than IDLE drops `ren_fifo` on the same cycle. A word already read is still written on the next cycle. The FSM then goes to IDLE with no `done` pulse.
- `start` and `abort` in the same cycle in IDLE: `abort` wins; `start` is ignored.
- `rst` mid-frame: all outputs are 0 at the next edge, partial progress is discarded, and no `done` pulse is issued.

## Timing
- `start` sampled at edge 0 → `busy` = 1 after edge 1.
- Read at edge n → BRAM write presented after edge n+1. Latency is one cycle.
- Within a burst, with the FIFO non-empty, throughput is one word per cycle. Between bursts there is at least one WAIT cycle.
- `done` is high for exactly one cycle. The cycle after it is either IDLE (`busy` = 0) or WAIT (`busy` stays 1, loop mode).
- `num_words` = 0: `done` pulses two cycles after `start`, with no `ren_fifo` and no writes.

## Structure
- Shared package `load_bram_pkg`:
  - FSM state enum: IDLE, WAIT, READ, DRAIN, DONE.
  - Byte-lane helper constant `DATA_W/8`.
  - The `min` function used for the burst size.
- Single flat module. No sub-module is needed; the burst counter, remaining counter and address register are local.

## Test plan
- Basic frame: base 0x100, `num_words` 4, `BURST_LEN` 16, FIFO preloaded with 1..4 → writes at 0x100/0x104/0x108/0x10C with data 1..4, then one `done` pulse and `busy` falls.
- Multi-burst frame: `num_words` 40, `BURST_LEN` 16, FIFO fed one word every 2 cycles → bursts of 16, 16 and 8 words. `ren_fifo` is never high while empty. The last write is at base+156.
- Loop mode: `num_words` 8, `loop_mode` 1 → the 9th write returns to `base_addr` and `done` pulses every 8 words. Assert abort mid-frame → in-flight word written, no further `ren_fifo`, `busy` = 0, no `done`.
- Zero length and ignored start: `num_words` 0 → `done` two cycles after `start`, no writes. A second `start` while `busy` → ignored, latched values unchanged.
- Reset mid-frame: assert `rst` after 5 of 20 words → every output 0 next cycle. A new `start` then writes from `base_addr` again.
- Address wrap: `ADDR_W` = 8, base 0xF8, 4 words → addresses 0xF8, 0xFC, 0x00, 0x04.

Source files
------------

// File: rtl/load_bram_pkg.sv
// rtl/load_bram_pkg.sv - shared FSM state, byte-lane and burst-size helpers for the BRAM burst loader
package load_bram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        READ,
        DRAIN,
        DONE
    } state_t;

    function automatic int unsigned byte_lanes(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/load_bram_burst.sv
// rtl/load_bram_burst.sv - drains a non-FWFT pixel FIFO in bursts into consecutive BRAM words
module load_bram_burst
    import load_bram_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int COUNT_W   = 11,
    parameter int LEN_W     = 20,
    parameter int BURST_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [LEN_W-1:0]      num_words,
    input  logic                  loop_mode,
    input  logic                  abort,
    output logic                  ren_fifo,
    input  logic [DATA_W-1:0]     din_fifo,
    input  logic                  empty_fifo,
    input  logic [COUNT_W-1:0]    rd_data_count_fifo,
    output logic                  en_bram,
    output logic [DATA_W/8-1:0]   we_bram,
    output logic [ADDR_W-1:0]     addr_bram,
    output logic [DATA_W-1:0]     din_bram,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned       LANES     = byte_lanes(DATA_W);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(LANES);

    state_t               state;
    state_t               state_nx;
    logic [ADDR_W-1:0]    base_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [LEN_W-1:0]     num_q;
    logic [LEN_W-1:0]     remaining;
    logic                 loop_q;
    logic [COUNT_W-1:0]   burst_cnt;
    logic [COUNT_W-1:0]   burst_b;
    logic                 rd_valid;
    logic                 start_ok;
    logic                 burst_ready;
    logic                 last_read;

    // The final burst of a frame may be shorter than BURST_LEN.
    always_comb begin
        burst_b     = COUNT_W'(min_u(BURST_LEN, 32'(remaining)));
        burst_ready = (rd_data_count_fifo >= burst_b);
        start_ok    = (state == IDLE) && start && !abort;
        last_read   = ren_fifo && (burst_cnt == COUNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nx = (num_words == '0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (burst_ready) begin
                    state_nx = READ;
                end
            end
            READ: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (last_read) begin
                    state_nx = (remaining != LEN_W'(1)) ? WAIT : DRAIN;
                end
            end
            DRAIN: begin
                state_nx = abort ? IDLE : DONE;
            end
            DONE: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (loop_q && (num_q != '0)) begin
                    state_nx = WAIT;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Abort masks the read combinationally so nothing new leaves the FIFO that cycle.
    always_comb begin
        ren_fifo = 1'b0;
        if ((state == READ) && (burst_cnt != '0) && !empty_fifo && !abort) begin
            ren_fifo = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q    <= '0;
            num_q     <= '0;
            loop_q    <= 1'b0;
            addr_q    <= '0;
            remaining <= '0;
            burst_cnt <= '0;
            rd_valid  <= 1'b0;
            en_bram   <= 1'b0;
            we_bram   <= '0;
            addr_bram <= '0;
            din_bram  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_valid <= ren_fifo;
            busy     <= (state != IDLE);
            done     <= (state == DONE) && !abort;
            en_bram  <= rd_valid;
            we_bram  <= {(DATA_W/8){rd_valid}};
            if (rd_valid) begin
                addr_bram <= addr_q;
                din_bram  <= din_fifo;
                addr_q    <= addr_q + ADDR_STEP;
            end
            if ((state == WAIT) && burst_ready) begin
                burst_cnt <= burst_b;
            end
            if (ren_fifo) begin
                burst_cnt <= burst_cnt - COUNT_W'(1);
                remaining <= remaining - LEN_W'(1);
            end
            if (start_ok) begin
                base_q    <= base_addr;
                num_q     <= num_words;
                loop_q    <= loop_mode;
                addr_q    <= base_addr;
                remaining <= num_words;
            end
            if ((state == DONE) && !abort && loop_q) begin
                addr_q    <= base_q;
                remaining <= num_q;
            end
        end
    end

endmodule

// File: tb/tb_load_bram_burst.sv
// tb/tb_load_bram_burst.sv - scoreboard bench for load_bram_burst with a non-FWFT FIFO model
module tb_load_bram_burst;

    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [19:0] num_words;
    logic        loop_mode;
    logic        abort;
    logic [31:0] din_fifo = '0;
    logic        empty_fifo;
    logic [10:0] rd_data_count_fifo;

    logic        ren_fifo, en_bram, busy, done;
    logic [3:0]  we_bram;
    logic [31:0] addr_bram, din_bram;

    logic        ren8, en8, busy8, done8;
    logic [3:0]  we8;
    logic [7:0]  addr8;
    logic [31:0] din8;

    always #5 clk = ~clk;

    load_bram_burst dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_words(num_words), .loop_mode(loop_mode), .abort(abort),
        .ren_fifo(ren_fifo), .din_fifo(din_fifo), .empty_fifo(empty_fifo),
        .rd_data_count_fifo(rd_data_count_fifo), .en_bram(en_bram),
        .we_bram(we_bram), .addr_bram(addr_bram), .din_bram(din_bram),
        .busy(busy), .done(done)
    );

    load_bram_burst #(.ADDR_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr[7:0]),
        .num_words(num_words), .loop_mode(loop_mode), .abort(abort),
        .ren_fifo(ren8), .din_fifo(din_fifo), .empty_fifo(empty_fifo),
        .rd_data_count_fifo(rd_data_count_fifo), .en_bram(en8),
        .we_bram(we8), .addr_bram(addr8), .din_bram(din8),
        .busy(busy8), .done(done8)
    );

    // FIFO model: pushes from the stimulus thread away from clock edges, pops on the edge.
    logic [31:0] fifo_mem [0:1023];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    always_comb begin
        empty_fifo         = (wr_ptr == rd_ptr);
        rd_data_count_fifo = 11'(wr_ptr - rd_ptr);
    end

    always @(posedge clk) begin
        if (ren_fifo && (wr_ptr != rd_ptr)) begin
            din_fifo <= fifo_mem[rd_ptr % 1024];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    // Write/done/burst monitor.
    logic sel8 = 1'b0;
    wr_t  mon_w;
    wr_t  obs_q[$];
    wr_t  exp_q[$];
    int   done_q[$];
    int   run_q[$];
    int   run_len = 0;
    int   viol = 0;

    always_comb mon_w = sel8 ? {we8, 24'd0, addr8, din8} : {we_bram, addr_bram, din_bram};

    always @(negedge clk) begin
        if (rst) begin
            run_len <= 0;
        end else begin
            if (sel8 ? en8 : en_bram) obs_q.push_back(mon_w);
            if (done) done_q.push_back(obs_q.size());
            if (ren_fifo && empty_fifo) viol <= viol + 1;
            if (ren_fifo) begin
                run_len <= run_len + 1;
            end else if (run_len != 0) begin
                run_q.push_back(run_len);
                run_len <= 0;
            end
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic push_word(input logic [31:0] d);
        fifo_mem[wr_ptr % 1024] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic flush_fifo();
        wr_ptr = rd_ptr;
    endtask

    task automatic do_start(input logic [31:0] b, input int n, input logic lp);
        @(posedge clk); #1;
        base_addr = b;
        num_words = 20'(n);
        loop_mode = lp;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #1;
            if (done_q.size() >= target) ok = 1'b1;
        end
    endtask

    task automatic wait_obs(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #1;
            if (obs_q.size() >= target) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; loop_mode = 1'b0;
        base_addr = '0; num_words = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (ren_fifo !== 1'b0) begin n_fail++; $display("FAIL reset_ren: got %b expected 0", ren_fifo); end
        n_cmp++; if (en_bram !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", en_bram); end
        n_cmp++; if (we_bram !== 4'h0) begin n_fail++; $display("FAIL reset_we: got %h expected 0", we_bram); end
        n_cmp++; if (addr_bram !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", addr_bram); end
        n_cmp++; if (din_bram !== 32'h0) begin n_fail++; $display("FAIL reset_din: got %h expected 0", din_bram); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int o0, e0, d0;
        bit ok;
        flush_fifo();
        o0 = obs_q.size(); e0 = exp_q.size(); d0 = done_q.size();
        for (int i = 0; i < 4; i++) begin
            push_word(32'(i + 1));
            exp_q.push_back({4'hF, 32'h100 + 32'(4 * i), 32'(i + 1)});
        end
        do_start(32'h100, 4, 1'b0);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_edge0: got %b expected 0", busy); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_edge1: got %b expected 1", busy); end
        wait_done(d0 + 1, 200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: got no done expected done"); end
        n_cmp++; if (obs_q.size() - o0 != exp_q.size() - e0) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", obs_q.size() - o0, exp_q.size() - e0); end
        for (int i = 0; i < exp_q.size() - e0; i++) begin
            n_cmp++;
            if (o0 + i >= obs_q.size() || obs_q[o0 + i] !== exp_q[e0 + i]) begin
                n_fail++; $display("FAIL basic_write[%0d]: got %h expected %h", i, (o0 + i < obs_q.size()) ? obs_q[o0 + i] : 'x, exp_q[e0 + i]);
            end
        end
        n_cmp++; if (done_q.size() <= d0 || done_q[d0] !== o0 + 4) begin n_fail++; $display("FAIL basic_done_pos: got %0d expected %0d", (done_q.size() > d0) ? done_q[d0] : -1, o0 + 4); end
        @(negedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b expected 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_multi_burst();
        int o0, e0, d0, r0;
        int exp_runs [3] = '{16, 16, 8};
        bit ok;
        flush_fifo();
        o0 = obs_q.size(); e0 = exp_q.size(); d0 = done_q.size(); r0 = run_q.size();
        for (int i = 0; i < 40; i++) exp_q.push_back({4'hF, 32'h800 + 32'(4 * i), 32'h2000 + 32'(i)});
        do_start(32'h800, 40, 1'b0);
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    push_word(32'h2000 + 32'(i));
                    repeat (2) @(posedge clk);
                    #1;
                end
            end
            wait_done(d0 + 1, 500, ok);
        join
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL multi_timeout: got no done expected done"); end
        n_cmp++; if (obs_q.size() - o0 != 40) begin n_fail++; $display("FAIL multi_count: got %0d expected 40", obs_q.size() - o0); end
        for (int i = 0; i < 40; i++) begin
            n_cmp++;
            if (o0 + i >= obs_q.size() || obs_q[o0 + i] !== exp_q[e0 + i]) begin
                n_fail++; $display("FAIL multi_write[%0d]: got %h expected %h", i, (o0 + i < obs_q.size()) ? obs_q[o0 + i] : 'x, exp_q[e0 + i]);
            end
        end
        n_cmp++; if (obs_q.size() < o0 + 40 || obs_q[o0 + 39].addr !== 32'h89C) begin n_fail++; $display("FAIL multi_last_addr: got %h expected 0000089c", (obs_q.size() >= o0 + 40) ? obs_q[o0 + 39].addr : 'x); end
        n_cmp++; if (run_q.size() - r0 != 3) begin n_fail++; $display("FAIL multi_bursts: got %0d expected 3", run_q.size() - r0); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (r0 + i >= run_q.size() || run_q[r0 + i] !== exp_runs[i]) begin
                n_fail++; $display("FAIL multi_burst_len[%0d]: got %0d expected %0d", i, (r0 + i < run_q.size()) ? run_q[r0 + i] : -1, exp_runs[i]);
            end
        end
        n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL multi_ren_empty: got %0d expected 0", viol); end
    endtask

    task automatic test_loop_abort();
        int o0, e0, d0, rp0;
        bit ok;
        flush_fifo();
        o0 = obs_q.size(); e0 = exp_q.size(); d0 = done_q.size(); rp0 = rd_ptr;
        for (int i = 0; i < 24; i++) push_word(32'h1000 + 32'(i));
        for (int i = 0; i < 19; i++) exp_q.push_back({4'hF, 32'h200 + 32'(4 * (i % 8)), 32'h1000 + 32'(i)});
        do_start(32'h200, 8, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk); #1;
            if (rd_ptr - rp0 >= 19) ok = 1'b1;
        end
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL loop_timeout: got %0d reads expected 19", rd_ptr - rp0); end
        abort = 1'b1;
        #1;
        n_cmp++; if (ren_fifo !== 1'b0) begin n_fail++; $display("FAIL loop_abort_ren: got %b expected 0", ren_fifo); end
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        n_cmp++; if (rd_ptr - rp0 != 19) begin n_fail++; $display("FAIL loop_reads_after_abort: got %0d expected 19", rd_ptr - rp0); end
        n_cmp++; if (obs_q.size() - o0 != 19) begin n_fail++; $display("FAIL loop_count: got %0d expected 19", obs_q.size() - o0); end
        for (int i = 0; i < 19; i++) begin
            n_cmp++;
            if (o0 + i >= obs_q.size() || obs_q[o0 + i] !== exp_q[e0 + i]) begin
                n_fail++; $display("FAIL loop_write[%0d]: got %h expected %h", i, (o0 + i < obs_q.size()) ? obs_q[o0 + i] : 'x, exp_q[e0 + i]);
            end
        end
        n_cmp++; if (done_q.size() - d0 != 2) begin n_fail++; $display("FAIL loop_done_count: got %0d expected 2", done_q.size() - d0); end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (d0 + i >= done_q.size() || done_q[d0 + i] !== o0 + 8 * (i + 1)) begin
                n_fail++; $display("FAIL loop_done_pos[%0d]: got %0d expected %0d", i, (d0 + i < done_q.size()) ? done_q[d0 + i] : -1, o0 + 8 * (i + 1));
            end
        end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL loop_busy_after_abort: got %b expected 0", busy); end
        flush_fifo();
    endtask

    task automatic test_zero_and_ignore();
        int o0, e0, d0;
        bit ok;
        flush_fifo();
        o0 = obs_q.size(); d0 = done_q.size();
        do_start(32'h500, 0, 1'b0);
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_early: got %b expected 0", done); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b expected 1", done); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b expected 0", busy); end
        n_cmp++; if (obs_q.size() != o0) begin n_fail++; $display("FAIL zero_writes: got %0d expected 0", obs_q.size() - o0); end
        o0 = obs_q.size(); e0 = exp_q.size(); d0 = done_q.size();
        for (int i = 0; i < 4; i++) exp_q.push_back({4'hF, 32'h300 + 32'(4 * i), 32'h3000 + 32'(i)});
        do_start(32'h300, 4, 1'b0);
        repeat (3) @(posedge clk);
        do_start(32'h900, 2, 1'b0);
        for (int i = 0; i < 4; i++) push_word(32'h3000 + 32'(i));
        wait_done(d0 + 1, 200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL ignore_timeout: got no done expected done"); end
        repeat (3) @(negedge clk);
        n_cmp++; if (obs_q.size() - o0 != 4) begin n_fail++; $display("FAIL ignore_count: got %0d expected 4", obs_q.size() - o0); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (o0 + i >= obs_q.size() || obs_q[o0 + i] !== exp_q[e0 + i]) begin
                n_fail++; $display("FAIL ignore_write[%0d]: got %h expected %h", i, (o0 + i < obs_q.size()) ? obs_q[o0 + i] : 'x, exp_q[e0 + i]);
            end
        end
        n_cmp++; if (done_q.size() - d0 != 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", done_q.size() - d0); end
    endtask

    task automatic test_reset_mid();
        int o0, e0, d0;
        bit ok;
        flush_fifo();
        o0 = obs_q.size(); e0 = exp_q.size(); d0 = done_q.size();
        for (int i = 0; i < 20; i++) push_word(32'h4000 + 32'(i));
        for (int i = 0; i < 5; i++) exp_q.push_back({4'hF, 32'h400 + 32'(4 * i), 32'h4000 + 32'(i)});
        do_start(32'h400, 20, 1'b0);
        wait_obs(o0 + 5, 200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rstmid_timeout: got %0d writes expected 5", obs_q.size() - o0); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        n_cmp++; if ({ren_fifo, en_bram, busy, done} !== 4'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got %b expected 0000", {ren_fifo, en_bram, busy, done}); end
        n_cmp++; if ({we_bram, addr_bram, din_bram} !== 68'h0) begin n_fail++; $display("FAIL rstmid_data: got %h expected 0", {we_bram, addr_bram, din_bram}); end
        rst = 1'b0;
        n_cmp++; if (obs_q.size() - o0 != 5) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 5", obs_q.size() - o0); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (o0 + i >= obs_q.size() || obs_q[o0 + i] !== exp_q[e0 + i]) begin
                n_fail++; $display("FAIL rstmid_write[%0d]: got %h expected %h", i, (o0 + i < obs_q.size()) ? obs_q[o0 + i] : 'x, exp_q[e0 + i]);
            end
        end
        flush_fifo();
        o0 = obs_q.size(); e0 = exp_q.size();
        for (int i = 0; i < 3; i++) begin
            push_word(32'h5000 + 32'(i));
            exp_q.push_back({4'hF, 32'h400 + 32'(4 * i), 32'h5000 + 32'(i)});
        end
        do_start(32'h400, 3, 1'b0);
        wait_done(d0 + 1, 200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rstmid_restart_timeout: got no done expected done"); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (o0 + i >= obs_q.size() || obs_q[o0 + i] !== exp_q[e0 + i]) begin
                n_fail++; $display("FAIL rstmid_restart[%0d]: got %h expected %h", i, (o0 + i < obs_q.size()) ? obs_q[o0 + i] : 'x, exp_q[e0 + i]);
            end
        end
        n_cmp++; if (done_q.size() - d0 != 1) begin n_fail++; $display("FAIL rstmid_done_count: got %0d expected 1", done_q.size() - d0); end
    endtask

    task automatic test_addr_wrap();
        int o0, e0, d0;
        logic [31:0] wrap_addr [4] = '{32'hF8, 32'hFC, 32'h00, 32'h04};
        bit ok;
        repeat (2) @(negedge clk);
        sel8 = 1'b1;
        flush_fifo();
        o0 = obs_q.size(); e0 = exp_q.size(); d0 = done_q.size();
        for (int i = 0; i < 4; i++) begin
            push_word(32'h6000 + 32'(i));
            exp_q.push_back({4'hF, wrap_addr[i], 32'h6000 + 32'(i)});
        end
        do_start(32'hF8, 4, 1'b0);
        wait_done(d0 + 1, 200, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout: got no done expected done"); end
        n_cmp++; if (obs_q.size() - o0 != 4) begin n_fail++; $display("FAIL wrap_count: got %0d expected 4", obs_q.size() - o0); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (o0 + i >= obs_q.size() || obs_q[o0 + i] !== exp_q[e0 + i]) begin
                n_fail++; $display("FAIL wrap_write[%0d]: got %h expected %h", i, (o0 + i < obs_q.size()) ? obs_q[o0 + i] : 'x, exp_q[e0 + i]);
            end
        end
        sel8 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; loop_mode = 1'b0;
        base_addr = '0; num_words = '0;
        test_reset();
        test_basic();
        test_multi_burst();
        test_loop_abort();
        test_zero_and_ignore();
        test_reset_mid();
        test_addr_wrap();
        n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL ren_while_empty: got %0d expected 0", viol); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
